// File: rtl/dds_sweep_ctrl.sv
// Frequency-sweep sequencer for the DDS phase accumulator: steps a tuning word
// from a start to a stop value, holding each word for a programmable dwell.
module dds_sweep_ctrl #(
    parameter int N       = 10,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [N-1:0]       cfg_start,
    input  logic [N-1:0]       cfg_stop,
    input  logic [N-1:0]       cfg_step,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               cfg_mode,
    output logic [N-1:0]       phase_inc,
    output logic               inc_valid,
    output logic               busy,
    output logic               done,
    output logic               cfg_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DWELL = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]         state_q,     state_d;
    logic [N-1:0]       phase_inc_q, phase_inc_d;
    logic               inc_valid_q, inc_valid_d;
    logic               busy_q,      busy_d;
    logic               done_q,      done_d;
    logic               cfg_err_q,   cfg_err_d;
    logic [DWELL_W-1:0] cnt_q,       cnt_d;
    logic [N-1:0]       start_q,     start_d;
    logic [N-1:0]       stop_q,      stop_d;
    logic [N-1:0]       step_q,      step_d;
    logic [DWELL_W-1:0] dwell_q,     dwell_d;
    logic               mode_q,      mode_d;
    logic [N:0]         next_word;

    // One extra bit so a step past the top of the range is seen as > stop
    // rather than wrapping back into range.
    assign next_word = {1'b0, phase_inc_q} + {1'b0, step_q};

    always_comb begin
        // NOTE: every _d gets a default up front so no path through the case
        // leaves a signal unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        phase_inc_d = phase_inc_q;
        inc_valid_d = inc_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;
        cnt_d       = cnt_q;
        start_d     = start_q;
        stop_d      = stop_q;
        step_d      = step_q;
        dwell_d     = dwell_q;
        mode_d      = mode_q;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (cfg_step == '0 || cfg_start > cfg_stop) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        start_d     = cfg_start;
                        stop_d      = cfg_stop;
                        step_d      = cfg_step;
                        dwell_d     = cfg_dwell;
                        mode_d      = cfg_mode;
                        phase_inc_d = cfg_start;
                        inc_valid_d = 1'b1;
                        busy_d      = 1'b1;
                        cnt_d       = cfg_dwell;
                        state_d     = S_DWELL;
                    end
                end
            end

            S_DWELL: begin
                if (abort) begin
                    state_d     = S_IDLE;
                    phase_inc_d = '0;
                    inc_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (next_word <= {1'b0, stop_q}) begin
                    phase_inc_d = next_word[N-1:0];
                    cnt_d       = dwell_q;
                end else if (mode_q) begin
                    phase_inc_d = start_q;
                    cnt_d       = dwell_q;
                end else begin
                    state_d     = S_DONE;
                    done_d      = 1'b1;
                    phase_inc_d = '0;
                    inc_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d     = S_IDLE;
                phase_inc_d = '0;
                inc_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of the others regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            phase_inc_q <= '0;
            inc_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            cnt_q       <= '0;
            start_q     <= '0;
            stop_q      <= '0;
            step_q      <= '0;
            dwell_q     <= '0;
            mode_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_inc_q <= phase_inc_d;
            inc_valid_q <= inc_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            stop_q      <= stop_d;
            step_q      <= step_d;
            dwell_q     <= dwell_d;
            mode_q      <= mode_d;
        end
    end

    assign phase_inc = phase_inc_q;
    assign inc_valid = inc_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl: directed and random sweeps compared
// cycle by cycle against a word-list reference model.
module tb_dds_sweep_ctrl;

    localparam int N       = 10;
    localparam int DWELL_W = 16;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               abort;
    logic [N-1:0]       cfg_start;
    logic [N-1:0]       cfg_stop;
    logic [N-1:0]       cfg_step;
    logic [DWELL_W-1:0] cfg_dwell;
    logic               cfg_mode;
    logic [N-1:0]       phase_inc;
    logic               inc_valid;
    logic               busy;
    logic               done;
    logic               cfg_err;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [N-1:0] pi;
        logic         v;
        logic         b;
        logic         d;
        logic         e;
    } obs_t;

    dds_sweep_ctrl #(.N(N), .DWELL_W(DWELL_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .cfg_step  (cfg_step),
        .cfg_dwell (cfg_dwell),
        .cfg_mode  (cfg_mode),
        .phase_inc (phase_inc),
        .inc_valid (inc_valid),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t mk(input int pi, input bit v, input bit b, input bit d, input bit e);
        obs_t o;
        o.pi = N'(pi);
        o.v  = v;
        o.b  = b;
        o.d  = d;
        o.e  = e;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.pi = phase_inc;
        o.v  = inc_valid;
        o.b  = busy;
        o.d  = done;
        o.e  = cfg_err;
        return o;
    endfunction

    // Reference: expand the word list into the per-cycle output trace, then
    // drive the sweep and compare each cycle after the start edge.
    // abort_after < 0 means no abort; otherwise abort is raised in the cycle
    // showing the abort_after-th active output.
    task automatic run_sweep(input string name, input int s, input int p, input int st,
                             input int dw, input bit md, input int abort_after,
                             input bit perturb);
        obs_t exp_q[$];
        int   words[$];
        int   total;
        int   ab;
        ab = -1;
        if (st == 0 || s > p) begin
            exp_q.push_back(mk(0, 0, 0, 0, 1));
        end else begin
            for (int w = s; w <= p; w += st) words.push_back(w);
            if (md) begin
                ab = abort_after;
                for (int k = 0; k < ab; k++)
                    exp_q.push_back(mk(words[(k / (dw + 1)) % words.size()], 1, 1, 0, 0));
            end else begin
                total = words.size() * (dw + 1);
                if (abort_after >= 0 && abort_after < total) ab = abort_after;
                foreach (words[k])
                    for (int r = 0; r <= dw; r++) exp_q.push_back(mk(words[k], 1, 1, 0, 0));
                if (ab >= 0) begin
                    while (exp_q.size() > ab) void'(exp_q.pop_back());
                end else begin
                    exp_q.push_back(mk(0, 0, 0, 1, 0));
                end
            end
        end
        exp_q.push_back(mk(0, 0, 0, 0, 0));
        exp_q.push_back(mk(0, 0, 0, 0, 0));

        cfg_start = N'(s);
        cfg_stop  = N'(p);
        cfg_step  = N'(st);
        cfg_dwell = DWELL_W'(dw);
        cfg_mode  = md;
        start     = 1'b1;
        abort     = 1'b0;
        @(posedge clk);
        @(negedge clk);
        foreach (exp_q[i]) begin
            start = 1'b0;
            abort = 1'b0;
            check($sformatf("%s[%0d]", name, i), 32'(sample()), 32'(exp_q[i]));
            if (ab >= 0 && i == ab - 1) abort = 1'b1;
            if (perturb && exp_q[i].b && (i % 3 == 1)) begin
                start     = 1'b1;
                cfg_step  = N'($urandom);
                cfg_start = N'($urandom);
                cfg_dwell = DWELL_W'($urandom_range(0, 7));
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        int s, p, st, dw, ab;
        bit md;
        rst_n     = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        cfg_start = '0;
        cfg_stop  = '0;
        cfg_step  = '0;
        cfg_dwell = '0;
        cfg_mode  = 1'b0;
        #12;
        check("reset_outputs", 32'(sample()), 32'(mk(0, 0, 0, 0, 0)));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_sweep("single_8_40",   8,    40,   10, 2, 1'b0, -1, 1'b0);
        run_sweep("no_wrap",       1000, 1023, 20, 0, 1'b0, -1, 1'b0);
        run_sweep("repeat_abort",  0,    20,   10, 0, 1'b1, 7,  1'b0);
        run_sweep("step_zero",     5,    40,   0,  1, 1'b0, -1, 1'b0);
        run_sweep("start_gt_stop", 50,   40,   5,  1, 1'b0, -1, 1'b0);
        run_sweep("stop_inclusive",10,   30,   10, 1, 1'b0, -1, 1'b0);
        run_sweep("single_word",   7,    7,    3,  2, 1'b0, -1, 1'b0);
        run_sweep("abort_single",  8,    40,   10, 2, 1'b0, 5,  1'b0);
        run_sweep("perturbed",     8,    40,   10, 2, 1'b0, -1, 1'b1);

        // abort together with start in IDLE: nothing happens
        cfg_start = 10'd3; cfg_stop = 10'd9; cfg_step = 10'd1; cfg_dwell = '0; cfg_mode = 1'b0;
        start = 1'b1; abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("abort_wins_c1", 32'(sample()), 32'(mk(0, 0, 0, 0, 0)));
        @(posedge clk);
        @(negedge clk);
        check("abort_wins_c2", 32'(sample()), 32'(mk(0, 0, 0, 0, 0)));

        // asynchronous reset mid-dwell, between clock edges
        cfg_start = 10'd100; cfg_stop = 10'd200; cfg_step = 10'd10; cfg_dwell = 16'd5;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("pre_reset_busy", 32'(sample()), 32'(mk(100, 1, 1, 0, 0)));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'(sample()), 32'(mk(0, 0, 0, 0, 0)));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_sweep("after_reset", 100, 130, 10, 1, 1'b0, -1, 1'b0);

        for (int t = 0; t < 40; t++) begin
            s  = int'($urandom_range(0, 1023));
            p  = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 5) != 0 && s > p) begin
                int tmp;
                tmp = s; s = p; p = tmp;
            end
            st = int'($urandom_range(0, 9)) == 0 ? 0 : (p - s) / 6 + int'($urandom_range(1, 40));
            dw = int'($urandom_range(0, 3));
            md = 1'($urandom_range(0, 1));
            ab = md ? int'($urandom_range(1, 30)) : ($urandom_range(0, 2) == 0 ? int'($urandom_range(1, 10)) : -1);
            run_sweep($sformatf("rand%0d", t), s, p, st, dw, md, ab, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
